// File: rtl/board_pkg.sv
// Shared definitions for the Gomoku display path: cell status codes,
// game outcome codes and the renderer's state encoding.
package board_pkg;

    // Width of one board cell's status field.
    localparam int STATUS_W = 2;

    // Per-cell status as delivered by the game core.
    typedef enum logic [STATUS_W-1:0] {
        CHESS_NONE  = 2'd0,
        CHESS_BLACK = 2'd1,
        CHESS_BLUE  = 2'd2,
        CHESS_WIN   = 2'd3
    } chess_e;

    // Game outcome as delivered by the game core.
    typedef enum logic [1:0] {
        WIN_GAMING = 2'b00,
        WIN_EQUAL  = 2'b01,
        WIN_BLACK  = 2'b10,
        WIN_BLUE   = 2'b11
    } win_e;

    // Frame renderer sequencing.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_FILL,
        ST_PTR,
        ST_DONE
    } render_state_e;

endpackage

// File: rtl/board_renderer_rect_filler.sv
// Rectangle pixel walker: emits one registered pixel write per clock in
// raster order over a w x h rectangle at (x0, y0). In outline mode only the
// border pixels carry a write strobe, but every pixel still costs a cycle.
// The first pixel is emitted on the same edge that samples start_i.
module rect_filler
    import board_pkg::*;
#(
    parameter int SCR_W      = 128,
    parameter int ADDR_BITS  = 14,
    parameter int COLOR_BITS = 3,
    parameter int XW         = 7,
    parameter int YW         = 7,
    parameter int DW         = 8
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic [XW-1:0]         x0_i,
    input  logic [YW-1:0]         y0_i,
    input  logic [DW-1:0]         w_i,
    input  logic [DW-1:0]         h_i,
    input  logic [COLOR_BITS-1:0] color_i,
    input  logic                  outline_only_i,
    input  logic                  start_i,
    output logic [ADDR_BITS-1:0]  address_o,
    output logic [COLOR_BITS-1:0] color_o,
    output logic                  print_enable_o,
    output logic                  done_o
);

    logic                  busy_q, busy_d;
    logic [XW-1:0]         x0_q, x0_d;
    logic [YW-1:0]         y0_q, y0_d;
    logic [DW-1:0]         w_q, w_d;
    logic [DW-1:0]         h_q, h_d;
    logic [COLOR_BITS-1:0] fill_color_q, fill_color_d;
    logic                  outline_q, outline_d;
    logic [DW-1:0]         cx_q, cx_d;
    logic [DW-1:0]         cy_q, cy_d;
    logic [ADDR_BITS-1:0]  address_q, address_d;
    logic [COLOR_BITS-1:0] color_q, color_d;
    logic                  pe_q, pe_d;
    logic                  done_q, done_d;

    // Pixel currently being emitted: latched parameters while busy,
    // live inputs on the starting edge.
    logic [XW-1:0]         sel_x0;
    logic [YW-1:0]         sel_y0;
    logic [DW-1:0]         sel_w, sel_h, sel_cx, sel_cy;
    logic [COLOR_BITS-1:0] sel_color;
    logic                  sel_outline;
    logic                  last_col, last_row, on_border;

    // Next-state: emit the selected pixel and advance the raster counters.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        busy_d       = busy_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        w_d          = w_q;
        h_d          = h_q;
        fill_color_d = fill_color_q;
        outline_d    = outline_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        address_d    = address_q;
        color_d      = color_q;
        pe_d         = 1'b0;
        done_d       = 1'b0;

        sel_x0      = busy_q ? x0_q         : x0_i;
        sel_y0      = busy_q ? y0_q         : y0_i;
        sel_w       = busy_q ? w_q          : w_i;
        sel_h       = busy_q ? h_q          : h_i;
        sel_color   = busy_q ? fill_color_q : color_i;
        sel_outline = busy_q ? outline_q    : outline_only_i;
        sel_cx      = busy_q ? cx_q         : '0;
        sel_cy      = busy_q ? cy_q         : '0;

        last_col  = (sel_cx == sel_w - DW'(1));
        last_row  = (sel_cy == sel_h - DW'(1));
        on_border = (sel_cx == '0) || last_col || (sel_cy == '0) || last_row;

        if (busy_q || start_i) begin
            x0_d         = sel_x0;
            y0_d         = sel_y0;
            w_d          = sel_w;
            h_d          = sel_h;
            fill_color_d = sel_color;
            outline_d    = sel_outline;
            address_d    = (ADDR_BITS'(sel_y0) + ADDR_BITS'(sel_cy)) * ADDR_BITS'(SCR_W)
                         + ADDR_BITS'(sel_x0) + ADDR_BITS'(sel_cx);
            color_d      = sel_color;
            pe_d         = !sel_outline || on_border;
            if (last_col) begin
                cx_d = '0;
                if (last_row) begin
                    cy_d   = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cy_d   = sel_cy + DW'(1);
                    busy_d = 1'b1;
                end
            end else begin
                cx_d   = sel_cx + DW'(1);
                cy_d   = sel_cy;
                busy_d = 1'b1;
            end
        end
    end

    // Control and output registers, cleared by the synchronous reset.
    always_ff @(posedge Clck) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!Reset) begin
            busy_q    <= 1'b0;
            address_q <= '0;
            color_q   <= '0;
            pe_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            address_q <= address_d;
            color_q   <= color_d;
            pe_q      <= pe_d;
            done_q    <= done_d;
        end
    end

    // Rectangle parameters and counters, reloaded on every start.
    always_ff @(posedge Clck) begin
        x0_q         <= x0_d;
        y0_q         <= y0_d;
        w_q          <= w_d;
        h_q          <= h_d;
        fill_color_q <= fill_color_d;
        outline_q    <= outline_d;
        cx_q         <= cx_d;
        cy_q         <= cy_d;
    end

    assign address_o      = address_q;
    assign color_o        = color_q;
    assign print_enable_o = pe_q;
    assign done_o         = done_q;

endmodule

// File: rtl/board_renderer.sv
// Gomoku frame renderer: turns a snapshot of board, outcome and pointer
// into per-pixel video memory writes, one pixel per clock. Supports a full
// clear-and-redraw or an incremental redraw against a shadow of the last
// rendered frame, and draws the pointer as a cell outline.
module board_renderer
    import board_pkg::*;
#(
    parameter int                    BOARD_W     = 16,
    parameter int                    BOARD_H     = 16,
    parameter int                    CELL_PX_W   = 8,
    parameter int                    CELL_PX_H   = 8,
    parameter int                    COLOR_BITS  = 3,
    parameter int                    ADDR_BITS   = 14,
    parameter logic [COLOR_BITS-1:0] BG_COLOR    = 3'b000,
    parameter logic [COLOR_BITS-1:0] BLACK_COLOR = 3'b010,
    parameter logic [COLOR_BITS-1:0] BLUE_COLOR  = 3'b001,
    parameter logic [COLOR_BITS-1:0] WIN_COLOR   = 3'b110,
    parameter logic [COLOR_BITS-1:0] PTR_COLOR   = 3'b111
) (
    input  logic                                 Clck,
    input  logic                                 Reset,
    input  logic                                 in_cont_signal,
    output logic                                 out_cont_signal,
    input  logic                                 next_out_cont_signal,
    input  logic                                 full_redraw,
    input  logic [STATUS_W*BOARD_W*BOARD_H-1:0]  board,
    input  logic [1:0]                           winning_information,
    input  logic [$clog2(BOARD_W)-1:0]           pointer_loc_x,
    input  logic [$clog2(BOARD_H)-1:0]           pointer_loc_y,
    output logic [ADDR_BITS-1:0]                 address,
    output logic [COLOR_BITS-1:0]                color,
    output logic                                 print_enable
);

    localparam int SCR_W      = BOARD_W * CELL_PX_W;
    localparam int SCR_H      = BOARD_H * CELL_PX_H;
    localparam int XW         = $clog2(BOARD_W);
    localparam int YW         = $clog2(BOARD_H);
    localparam int PXW        = $clog2(SCR_W);
    localparam int PYW        = $clog2(SCR_H);
    localparam int DW         = $clog2(((SCR_W > SCR_H) ? SCR_W : SCR_H) + 1);
    localparam int CELLS      = BOARD_W * BOARD_H;
    localparam int BOARD_BITS = STATUS_W * CELLS;
    localparam int CIW        = $clog2(CELLS);
    localparam int BIW        = $clog2(BOARD_BITS);

    // Sequencing and frame-persistent state.
    render_state_e         state_q, state_d;
    logic                  out_cont_q, out_cont_d;
    logic                  first_q, first_d;
    logic [BOARD_BITS-1:0] shadow_q, shadow_d;
    logic [XW-1:0]         prev_ptr_x_q, prev_ptr_x_d;
    logic [YW-1:0]         prev_ptr_y_q, prev_ptr_y_d;
    logic                  f_start_q, f_start_d;

    // Per-frame snapshot, scan position and filler request parameters.
    logic [BOARD_BITS-1:0] snap_board_q, snap_board_d;
    win_e                  snap_win_q, snap_win_d;
    logic [XW-1:0]         snap_ptr_x_q, snap_ptr_x_d;
    logic [YW-1:0]         snap_ptr_y_q, snap_ptr_y_d;
    logic                  eff_full_q, eff_full_d;
    logic [XW-1:0]         cell_x_q, cell_x_d;
    logic [YW-1:0]         cell_y_q, cell_y_d;
    logic [PXW-1:0]        f_x0_q, f_x0_d;
    logic [PYW-1:0]        f_y0_q, f_y0_d;
    logic [DW-1:0]         f_w_q, f_w_d;
    logic [DW-1:0]         f_h_q, f_h_d;
    logic [COLOR_BITS-1:0] f_color_q, f_color_d;
    logic                  f_outline_q, f_outline_d;

    // Scan-time decode of the current cell.
    logic [CIW-1:0]        cell_idx;
    logic [BIW-1:0]        bit_idx;
    chess_e                cur_status, old_status;
    logic                  is_prev_ptr, draw_cell, last_cell, win_decided;
    logic [XW-1:0]         ptr_x_clamped;
    logic [YW-1:0]         ptr_y_clamped;
    logic                  f_done;

    // Off-board pointer coordinates are pinned to the last column/row.
    if ((1 << XW) > BOARD_W) begin : g_clamp_x
        assign ptr_x_clamped = (pointer_loc_x > XW'(BOARD_W - 1)) ? XW'(BOARD_W - 1) : pointer_loc_x;
    end else begin : g_pass_x
        assign ptr_x_clamped = pointer_loc_x;
    end
    if ((1 << YW) > BOARD_H) begin : g_clamp_y
        assign ptr_y_clamped = (pointer_loc_y > YW'(BOARD_H - 1)) ? YW'(BOARD_H - 1) : pointer_loc_y;
    end else begin : g_pass_y
        assign ptr_y_clamped = pointer_loc_y;
    end

    // A win-status cell is only highlighted once a player has actually won.
    function automatic logic [COLOR_BITS-1:0] status_color(input chess_e s, input logic won);
        case (s)
            CHESS_BLACK: status_color = BLACK_COLOR;
            CHESS_BLUE:  status_color = BLUE_COLOR;
            CHESS_WIN:   status_color = won ? WIN_COLOR : BG_COLOR;
            default:     status_color = BG_COLOR;
        endcase
    endfunction

    // Next-state: frame sequencing, scan decisions and filler requests.
    always_comb begin
        state_d      = state_q;
        out_cont_d   = out_cont_q;
        first_d      = first_q;
        shadow_d     = shadow_q;
        prev_ptr_x_d = prev_ptr_x_q;
        prev_ptr_y_d = prev_ptr_y_q;
        f_start_d    = 1'b0;
        snap_board_d = snap_board_q;
        snap_win_d   = snap_win_q;
        snap_ptr_x_d = snap_ptr_x_q;
        snap_ptr_y_d = snap_ptr_y_q;
        eff_full_d   = eff_full_q;
        cell_x_d     = cell_x_q;
        cell_y_d     = cell_y_q;
        f_x0_d       = f_x0_q;
        f_y0_d       = f_y0_q;
        f_w_d        = f_w_q;
        f_h_d        = f_h_q;
        f_color_d    = f_color_q;
        f_outline_d  = f_outline_q;

        cell_idx    = CIW'(cell_y_q) * CIW'(BOARD_W) + CIW'(cell_x_q);
        bit_idx     = BIW'(cell_idx) * BIW'(STATUS_W);
        cur_status  = chess_e'(snap_board_q[bit_idx +: STATUS_W]);
        old_status  = chess_e'(shadow_q[bit_idx +: STATUS_W]);
        win_decided = (snap_win_q == WIN_BLACK) || (snap_win_q == WIN_BLUE);
        is_prev_ptr = (cell_x_q == prev_ptr_x_q) && (cell_y_q == prev_ptr_y_q);
        last_cell   = (cell_x_q == XW'(BOARD_W - 1)) && (cell_y_q == YW'(BOARD_H - 1));
        draw_cell   = eff_full_q ? (cur_status != CHESS_NONE)
                                 : ((cur_status != old_status) || is_prev_ptr);

        case (state_q)
            ST_IDLE: begin
                if (in_cont_signal && !out_cont_q) begin
                    snap_board_d = board;
                    snap_win_d   = win_e'(winning_information);
                    snap_ptr_x_d = ptr_x_clamped;
                    snap_ptr_y_d = ptr_y_clamped;
                    eff_full_d   = full_redraw || first_q;
                    cell_x_d     = '0;
                    cell_y_d     = '0;
                    if (full_redraw || first_q) begin
                        state_d     = ST_CLEAR;
                        f_start_d   = 1'b1;
                        f_x0_d      = '0;
                        f_y0_d      = '0;
                        f_w_d       = DW'(SCR_W);
                        f_h_d       = DW'(SCR_H);
                        f_color_d   = BG_COLOR;
                        f_outline_d = 1'b0;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_CLEAR: begin
                if (f_done) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (draw_cell) begin
                    state_d     = ST_FILL;
                    f_start_d   = 1'b1;
                    f_x0_d      = PXW'(cell_x_q) * PXW'(CELL_PX_W);
                    f_y0_d      = PYW'(cell_y_q) * PYW'(CELL_PX_H);
                    f_w_d       = DW'(CELL_PX_W);
                    f_h_d       = DW'(CELL_PX_H);
                    f_color_d   = status_color(cur_status, win_decided);
                    f_outline_d = 1'b0;
                end else if (last_cell) begin
                    state_d     = ST_PTR;
                    f_start_d   = 1'b1;
                    f_x0_d      = PXW'(snap_ptr_x_q) * PXW'(CELL_PX_W);
                    f_y0_d      = PYW'(snap_ptr_y_q) * PYW'(CELL_PX_H);
                    f_w_d       = DW'(CELL_PX_W);
                    f_h_d       = DW'(CELL_PX_H);
                    f_color_d   = PTR_COLOR;
                    f_outline_d = 1'b1;
                end else if (cell_x_q == XW'(BOARD_W - 1)) begin
                    cell_x_d = '0;
                    cell_y_d = cell_y_q + YW'(1);
                end else begin
                    cell_x_d = cell_x_q + XW'(1);
                end
            end
            ST_FILL: begin
                if (f_done) begin
                    if (last_cell) begin
                        state_d     = ST_PTR;
                        f_start_d   = 1'b1;
                        f_x0_d      = PXW'(snap_ptr_x_q) * PXW'(CELL_PX_W);
                        f_y0_d      = PYW'(snap_ptr_y_q) * PYW'(CELL_PX_H);
                        f_w_d       = DW'(CELL_PX_W);
                        f_h_d       = DW'(CELL_PX_H);
                        f_color_d   = PTR_COLOR;
                        f_outline_d = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                        if (cell_x_q == XW'(BOARD_W - 1)) begin
                            cell_x_d = '0;
                            cell_y_d = cell_y_q + YW'(1);
                        end else begin
                            cell_x_d = cell_x_q + XW'(1);
                        end
                    end
                end
            end
            ST_PTR: begin
                if (f_done) begin
                    state_d      = ST_DONE;
                    out_cont_d   = 1'b1;
                    shadow_d     = snap_board_q;
                    prev_ptr_x_d = snap_ptr_x_q;
                    prev_ptr_y_d = snap_ptr_y_q;
                    first_d      = 1'b0;
                end
            end
            ST_DONE: begin
                if (next_out_cont_signal) begin
                    out_cont_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, shadow board and previous pointer, cleared on reset.
    always_ff @(posedge Clck) begin
        // NOTE: the shadow board is reset so it matches a blank screen; the
        // snapshot and scan registers below are not, since each frame start
        // loads them before anything reads them.
        if (!Reset) begin
            state_q      <= ST_IDLE;
            out_cont_q   <= 1'b0;
            first_q      <= 1'b1;
            shadow_q     <= '0;
            prev_ptr_x_q <= '0;
            prev_ptr_y_q <= '0;
            f_start_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_cont_q   <= out_cont_d;
            first_q      <= first_d;
            shadow_q     <= shadow_d;
            prev_ptr_x_q <= prev_ptr_x_d;
            prev_ptr_y_q <= prev_ptr_y_d;
            f_start_q    <= f_start_d;
        end
    end

    // Frame snapshot, scan position and filler request parameters.
    always_ff @(posedge Clck) begin
        snap_board_q <= snap_board_d;
        snap_win_q   <= snap_win_d;
        snap_ptr_x_q <= snap_ptr_x_d;
        snap_ptr_y_q <= snap_ptr_y_d;
        eff_full_q   <= eff_full_d;
        cell_x_q     <= cell_x_d;
        cell_y_q     <= cell_y_d;
        f_x0_q       <= f_x0_d;
        f_y0_q       <= f_y0_d;
        f_w_q        <= f_w_d;
        f_h_q        <= f_h_d;
        f_color_q    <= f_color_d;
        f_outline_q  <= f_outline_d;
    end

    rect_filler #(
        .SCR_W      (SCR_W),
        .ADDR_BITS  (ADDR_BITS),
        .COLOR_BITS (COLOR_BITS),
        .XW         (PXW),
        .YW         (PYW),
        .DW         (DW)
    ) u_filler (
        .Clck           (Clck),
        .Reset          (Reset),
        .x0_i           (f_x0_q),
        .y0_i           (f_y0_q),
        .w_i            (f_w_q),
        .h_i            (f_h_q),
        .color_i        (f_color_q),
        .outline_only_i (f_outline_q),
        .start_i        (f_start_q),
        .address_o      (address),
        .color_o        (color),
        .print_enable_o (print_enable),
        .done_o         (f_done)
    );

    assign out_cont_signal = out_cont_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer with default parameters: counts every
// pixel write per colour and per watched rectangle, then checks each frame
// against hand-computed totals.
module tb_board_renderer;

    localparam int SCR_W = 128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_cont;
    logic         out_cont;
    logic         next_out;
    logic         full_redraw;
    logic [511:0] board;
    logic [1:0]   win_info;
    logic [3:0]   ptr_x, ptr_y;
    logic [13:0]  address;
    logic [2:0]   color;
    logic         print_enable;

    int checks   = 0;
    int failures = 0;

    // Cumulative write counters, written only by the monitor.
    int w_total = 0;
    int seq_err = 0;
    int ptr_border = 0;
    int w_col[8];
    int a_col[8];
    int b_col[8];

    // Per-frame settings and deltas, written only by the stimulus.
    int base_total, base_ptr;
    int b_wcol[8], b_acol[8], b_bcol[8];
    int d_total, d_ptr;
    int d_col[8], d_a[8], d_b[8];
    int seq_len = 0;
    int ra_x0 = 0, ra_y0 = 0, rb_x0 = 0, rb_y0 = 0, pr_x0 = 0, pr_y0 = 0;

    board_renderer dut (
        .Clck                 (clk),
        .Reset                (rst_n),
        .in_cont_signal       (in_cont),
        .out_cont_signal      (out_cont),
        .next_out_cont_signal (next_out),
        .full_redraw          (full_redraw),
        .board                (board),
        .winning_information  (win_info),
        .pointer_loc_x        (ptr_x),
        .pointer_loc_y        (ptr_y),
        .address              (address),
        .color                (color),
        .print_enable         (print_enable)
    );

    always #5 clk = ~clk;

    initial begin
        for (int c = 0; c < 8; c++) begin
            w_col[c] = 0;
            a_col[c] = 0;
            b_col[c] = 0;
        end
    end

    // Write monitor, sampling on the falling edge.
    always @(negedge clk) begin : monitor
        int idx, px, py;
        if (print_enable === 1'b1) begin
            idx = w_total - base_total;
            if (idx < seq_len && int'(address) != idx) seq_err++;
            px = int'(address) % SCR_W;
            py = int'(address) / SCR_W;
            w_total++;
            w_col[color]++;
            if (px >= ra_x0 && px < ra_x0 + 8 && py >= ra_y0 && py < ra_y0 + 8) a_col[color]++;
            if (px >= rb_x0 && px < rb_x0 + 8 && py >= rb_y0 && py < rb_y0 + 8) b_col[color]++;
            if (color == 3'b111 && px >= pr_x0 && px < pr_x0 + 8 && py >= pr_y0 && py < pr_y0 + 8 &&
                (px == pr_x0 || px == pr_x0 + 7 || py == pr_y0 || py == pr_y0 + 7))
                ptr_border++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cell(input int x, input int y, input logic [1:0] v);
        board[2*(y*16+x) +: 2] = v;
    endtask

    // Watched rectangles in cell units: A, B and the expected pointer cell.
    task automatic set_rects(input int ax, input int ay, input int bx, input int by,
                             input int px, input int py);
        ra_x0 = ax * 8; ra_y0 = ay * 8;
        rb_x0 = bx * 8; rb_y0 = by * 8;
        pr_x0 = px * 8; pr_y0 = py * 8;
    endtask

    task automatic mark_base(input int exp_seq);
        base_total = w_total;
        base_ptr   = ptr_border;
        seq_len    = exp_seq;
        for (int c = 0; c < 8; c++) begin
            b_wcol[c] = w_col[c];
            b_acol[c] = a_col[c];
            b_bcol[c] = b_col[c];
        end
    endtask

    // Start a frame, wait (bounded) for done, compute the per-frame deltas.
    task automatic run_frame(input string tag, input logic fr, input int exp_seq);
        int cyc;
        full_redraw = fr;
        mark_base(exp_seq);
        in_cont = 1'b1;
        @(negedge clk);
        in_cont = 1'b0;
        cyc = 0;
        while (out_cont !== 1'b1 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, 32'(out_cont), 32'd1);
        d_total = w_total - base_total;
        d_ptr   = ptr_border - base_ptr;
        for (int c = 0; c < 8; c++) begin
            d_col[c] = w_col[c] - b_wcol[c];
            d_a[c]   = a_col[c] - b_acol[c];
            d_b[c]   = b_col[c] - b_bcol[c];
        end
    endtask

    task automatic ack_frame(input string tag);
        next_out = 1'b1;
        @(negedge clk);
        check({tag, "_ack_fall"}, 32'(out_cont), 32'd0);
        next_out = 1'b0;
    endtask

    initial begin
        int cyc, held_base;
        rst_n = 1'b0; in_cont = 1'b0; next_out = 1'b0; full_redraw = 1'b0;
        board = '0; win_info = 2'b00; ptr_x = 4'd0; ptr_y = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_out_cont", 32'(out_cont), 32'd0);
        check("rst_pe", 32'(print_enable), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_color", 32'(color), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: forced full frame, empty board, pointer (0,0).
        set_rects(0, 0, 0, 0, 0, 0);
        run_frame("f1", 1'b0, 16384);
        check("f1_total", d_total, 16384 + 28);
        check("f1_bg", d_col[0], 16384);
        check("f1_clear_order", seq_err, 0);
        check("f1_ptr_cnt", d_col[7], 28);
        check("f1_ptr_border", d_ptr, 28);
        held_base = w_total;
        repeat (10) @(negedge clk);
        check("f1_hold_high", 32'(out_cont), 32'd1);
        check("f1_hold_nowrite", w_total - held_base, 0);
        ack_frame("f1");

        // Frame 2: cell (3,2) black, pointer still (0,0).
        set_cell(3, 2, 2'd1);
        set_rects(3, 2, 0, 0, 0, 0);
        run_frame("f2", 1'b0, 0);
        check("f2_total", d_total, 64 + 64 + 28);
        check("f2_black", d_col[2], 64);
        check("f2_black_in_cell", d_a[2], 64);
        check("f2_bg_in_ptrcell", d_b[0], 64);
        check("f2_ptr_border", d_ptr, 28);
        ack_frame("f2");

        // Frame 3: cell (5,5) win status with black winning.
        set_cell(5, 5, 2'd3);
        win_info = 2'b10;
        set_rects(5, 5, 0, 0, 0, 0);
        run_frame("f3", 1'b0, 0);
        check("f3_total", d_total, 156);
        check("f3_win_in_cell", d_a[6], 64);
        check("f3_win_total", d_col[6], 64);
        ack_frame("f3");

        // Frame 4: cell (5,5) cleared, game back to in-progress.
        set_cell(5, 5, 2'd0);
        win_info = 2'b00;
        run_frame("f4", 1'b0, 0);
        check("f4_total", d_total, 156);
        check("f4_bg_in_cell", d_a[0], 64);
        ack_frame("f4");

        // Frame 5: cell (5,5) win status but no winner: drawn as background.
        set_cell(5, 5, 2'd3);
        run_frame("f5", 1'b0, 0);
        check("f5_total", d_total, 156);
        check("f5_win_none", d_col[6], 0);
        check("f5_bg_in_cell", d_a[0], 64);
        check("f5_bg_total", d_col[0], 128);
        ack_frame("f5");

        // Frame 6: pointer moves (0,0) -> (15,15).
        ptr_x = 4'd15; ptr_y = 4'd15;
        set_rects(15, 15, 0, 0, 15, 15);
        run_frame("f6", 1'b0, 0);
        check("f6_total", d_total, 64 + 28);
        check("f6_old_ptr_bg", d_b[0], 64);
        check("f6_ptr_cnt", d_col[7], 28);
        check("f6_ptr_border", d_ptr, 28);
        ack_frame("f6");

        // Frame 7: pointer stays at the last cell, which ends the scan.
        run_frame("f7", 1'b0, 0);
        check("f7_total", d_total, 64 + 28);
        check("f7_last_cell_bg", d_a[0], 64);
        check("f7_ptr_border", d_ptr, 28);

        // Reset during a cell fill, with out_cont still high from frame 7.
        next_out = 1'b1;
        @(negedge clk);
        next_out = 1'b0;
        in_cont = 1'b1;
        @(negedge clk);
        in_cont = 1'b0;
        cyc = 0;
        while (print_enable !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_fill_seen", 32'(print_enable), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_pe", 32'(print_enable), 32'd0);
        check("mid_rst_out", 32'(out_cont), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 8: first after reset must be full even with full_redraw low.
        win_info = 2'b11;
        set_rects(5, 5, 3, 2, 15, 15);
        run_frame("f8", 1'b0, 16384);
        check("f8_total", d_total, 16384 + 64 + 64 + 28);
        check("f8_clear_order", seq_err, 0);
        check("f8_bg", d_col[0], 16384);
        check("f8_win_in_cell", d_a[6], 64);
        check("f8_black_in_cell", d_b[2], 64);
        check("f8_ptr_border", d_ptr, 28);
        ack_frame("f8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
